// File: rtl/sha3_scan_pkg.sv
// Shared types and constants for the SHA3/Keccak nonce scanner.
//   lane_t / state_t : one 64-bit Keccak lane and the 25-lane state (lane x+5y)
//   RC / ROT         : iota round constants and rho rotation offsets
//   PAD_*            : padding bytes dropped into the first absorbed block
//   scan_state_e     : scanner FSM states
//   rotl()           : 64-bit rotate-left helper
package sha3_scan_pkg;

  typedef logic [63:0] lane_t;
  typedef lane_t [24:0] state_t;

  localparam lane_t RC [24] = '{
    64'h0000_0000_0000_0001, 64'h0000_0000_0000_8082,
    64'h8000_0000_0000_808A, 64'h8000_0000_8000_8000,
    64'h0000_0000_0000_808B, 64'h0000_0000_8000_0001,
    64'h8000_0000_8000_8081, 64'h8000_0000_0000_8009,
    64'h0000_0000_0000_008A, 64'h0000_0000_0000_0088,
    64'h0000_0000_8000_8009, 64'h0000_0000_8000_000A,
    64'h0000_0000_8000_808B, 64'h8000_0000_0000_008B,
    64'h8000_0000_0000_8089, 64'h8000_0000_0000_8003,
    64'h8000_0000_0000_8002, 64'h8000_0000_0000_0080,
    64'h0000_0000_0000_800A, 64'h8000_0000_8000_000A,
    64'h8000_0000_8000_8081, 64'h8000_0000_0000_8080,
    64'h0000_0000_8000_0001, 64'h8000_0000_8000_8008
  };

  // Rho offsets indexed by lane x+5y.
  localparam int unsigned ROT [25] = '{
     0,  1, 62, 28, 27,
    36, 44,  6, 55, 20,
     3, 10, 43, 25, 39,
    41, 45, 15, 21,  8,
    18,  2, 61, 56, 14
  };

  localparam lane_t PAD_SHA3   = 64'h0000_0000_0000_0006;
  localparam lane_t PAD_KECCAK = 64'h0000_0000_0000_0001;
  localparam lane_t PAD_END    = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_EVAL
  } scan_state_e;

  function automatic lane_t rotl(input lane_t v, input int unsigned n);
    return (n == 0) ? v : ((v << n) | (v >> (64 - n)));
  endfunction

endpackage

// File: rtl/sha3_round.sv
// One Keccak-f[1600] round (theta, rho, pi, chi, iota), purely combinational.
//   state_in  : state before the round
//   round_idx : round number 0..23, selects the iota constant
//   state_out : state after the round
module sha3_round
  import sha3_scan_pkg::*;
(
  input  state_t     state_in,
  input  logic [4:0] round_idx,
  output state_t     state_out
);

  lane_t  col [5];
  lane_t  dmix [5];
  state_t theta;
  state_t pi_out;

  always_comb begin
    // NOTE: every variable gets a full default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    col       = '{default: '0};
    dmix      = '{default: '0};
    theta     = '0;
    pi_out    = '0;
    state_out = '0;

    for (int x = 0; x < 5; x++)
      col[x] = state_in[x] ^ state_in[x+5] ^ state_in[x+10] ^ state_in[x+15] ^ state_in[x+20];
    for (int x = 0; x < 5; x++)
      dmix[x] = col[(x+4)%5] ^ rotl(col[(x+1)%5], 1);
    for (int i = 0; i < 25; i++)
      theta[i] = state_in[i] ^ dmix[i%5];

    // Rho rotates each lane in place, pi moves lane (x,y) to (y, 2x+3y).
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        pi_out[y + 5*((2*x + 3*y) % 5)] = rotl(theta[x + 5*y], ROT[x + 5*y]);

    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        state_out[x + 5*y] = pi_out[x + 5*y] ^ (~pi_out[(x+1)%5 + 5*y] & pi_out[(x+2)%5 + 5*y]);

    state_out[0] = state_out[0] ^ RC[round_idx];
  end

endmodule

// File: rtl/sha3_nonce_scan_core.sv
// Iterative SHA3/Keccak nonce scanner. Latches a work blob, then for each of
// SCAN_COUNT consecutive nonces runs Keccak-f[1600] and compares lane 0 of the
// result against threshold, pulsing ocapture on the first passing nonce.
//   clk, rst       : clock, synchronous active-high reset
//   start          : one-cycle request, honoured only while idle
//   blobby         : INPUT_ELEMENTS x 32-bit work blob; last word is the nonce
//   threshold      : 64-bit unsigned pass limit, used in the EVAL cycle
//   ocapture       : ohash/ononce hold a passing result this cycle
//   ohash, ononce  : permuted state and the nonce that produced it
//   odispatching   : nonces remain to be tested
//   oawaiting      : a hash is in flight
//   oevaluating    : threshold comparison this cycle
//   scan_count     : constant SCAN_COUNT
// Build option: SHA3_SCAN_DOUBLE_ROUND_EN chains two rounds per clock
// (12 round clocks, 14-clock period) with bit-identical results.
module sha3_nonce_scan_core
  import sha3_scan_pkg::*;
#(
  parameter  int unsigned PROPER         = 1,
  parameter  int unsigned SCAN_COUNT     = 4096,
  localparam int          INPUT_ELEMENTS = (PROPER != 0) ? 20 : 24
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [INPUT_ELEMENTS-1:0][31:0]    blobby,
  input  logic [63:0]                        threshold,
  output logic                               ocapture,
  output state_t                             ohash,
  output logic [31:0]                        ononce,
  output logic                               odispatching,
  output logic                               oawaiting,
  output logic                               oevaluating,
  output logic [31:0]                        scan_count
);

  scan_state_e                     state_q, state_d;
  logic [INPUT_ELEMENTS-1:0][31:0] blob_q;
  logic [31:0]                     nonce_q;
  logic [31:0]                     tested_q;
  logic [4:0]                      round_q;
  state_t                          keccak_q;
  state_t                          hash_q;
  logic [31:0]                     ononce_q;

  state_t load_state;
  state_t round_a;
  state_t round_out;

  sha3_round u_round_a (
    .state_in  (keccak_q),
    .round_idx (round_q),
    .state_out (round_a)
  );

`ifdef SHA3_SCAN_DOUBLE_ROUND_EN
  localparam logic [4:0] ROUND_STEP = 5'd2;

  sha3_round u_round_b (
    .state_in  (round_a),
    .round_idx (round_q + 5'd1),
    .state_out (round_out)
  );
`else
  localparam logic [4:0] ROUND_STEP = 5'd1;

  assign round_out = round_a;
`endif

  localparam logic [4:0] LAST_ROUND = 5'd24 - ROUND_STEP;

  logic last_round, last_nonce, pass;

  assign last_round = (round_q == LAST_ROUND);
  assign last_nonce = (tested_q == 32'(SCAN_COUNT - 1));
  assign pass       = (hash_q[0] <= threshold);

  // First absorbed block: blob lanes with the live nonce in the top half of
  // the last blob lane, then the domain pad and the final rate bit.
  always_comb begin
    load_state = '0;
    for (int i = 0; i < INPUT_ELEMENTS/2; i++)
      load_state[i] = {blob_q[2*i+1], blob_q[2*i]};
    load_state[INPUT_ELEMENTS/2-1][63:32] = nonce_q;
    if (PROPER != 0) load_state[10] = PAD_SHA3;
    else             load_state[12] = PAD_KECCAK;
    load_state[16] = PAD_END;
  end

  always_comb begin
    state_d      = state_q;
    ocapture     = 1'b0;
    odispatching = 1'b0;
    oawaiting    = 1'b0;
    oevaluating  = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        odispatching = 1'b1;
        oawaiting    = 1'b1;
        state_d      = S_ROUND;
      end
      S_ROUND: begin
        odispatching = 1'b1;
        oawaiting    = 1'b1;
        if (last_round) state_d = S_EVAL;
      end
      S_EVAL: begin
        oawaiting   = 1'b1;
        oevaluating = 1'b1;
        ocapture    = pass;
        if (pass || last_nonce) begin
          state_d = S_IDLE;
        end else begin
          odispatching = 1'b1;
          state_d      = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with <= so every register samples the
    // values from before this edge, independent of statement order.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the wide state arrays are cleared here too; a reset mid-scan must
      // leave ohash at zero rather than exposing a partial permutation.
      blob_q   <= '0;
      nonce_q  <= '0;
      tested_q <= '0;
      round_q  <= '0;
      keccak_q <= '0;
      hash_q   <= '0;
      ononce_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          blob_q   <= blobby;
          nonce_q  <= blobby[INPUT_ELEMENTS-1];
          tested_q <= '0;
        end
        S_LOAD: begin
          keccak_q <= load_state;
          round_q  <= '0;
        end
        S_ROUND: begin
          keccak_q <= round_out;
          round_q  <= round_q + ROUND_STEP;
          // Result registers change only when a permutation completes, so
          // they stay stable through EVAL and the following idle/LOAD time.
          if (last_round) begin
            hash_q   <= round_out;
            ononce_q <= nonce_q;
          end
        end
        S_EVAL: if (state_d == S_LOAD) begin
          nonce_q  <= nonce_q + 32'd1;
          tested_q <= tested_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign ohash      = hash_q;
  assign ononce     = ononce_q;
  assign scan_count = 32'(SCAN_COUNT);

endmodule

// File: tb/tb_sha3_nonce_scan_core.sv
module tb_sha3_nonce_scan_core;

`ifdef SHA3_SCAN_DOUBLE_ROUND_EN
  localparam int PERIOD = 14;
`else
  localparam int PERIOD = 26;
`endif
  localparam int CNT_SHA3   = 4;
  localparam int CNT_KECCAK = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start1 = 1'b0;
  logic                  start0 = 1'b0;
  logic [23:0][31:0]     blob_w = '0;
  logic [63:0]           threshold = '0;
  logic                  sel0 = 1'b0;

  logic                  cap1, disp1, await1, eval1;
  logic [24:0][63:0]     hash1;
  logic [31:0]           nonce1, sc1;
  logic                  cap0, disp0, await0, eval0;
  logic [24:0][63:0]     hash0;
  logic [31:0]           nonce0, sc0;

  logic                  m_cap, m_disp, m_await, m_eval;
  logic [24:0][63:0]     m_hash;
  logic [31:0]           m_nonce;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  sha3_nonce_scan_core #(.PROPER(1), .SCAN_COUNT(CNT_SHA3)) u_dut_sha3 (
    .clk(clk), .rst(rst), .start(start1), .blobby(blob_w[19:0]), .threshold(threshold),
    .ocapture(cap1), .ohash(hash1), .ononce(nonce1), .odispatching(disp1),
    .oawaiting(await1), .oevaluating(eval1), .scan_count(sc1)
  );

  sha3_nonce_scan_core #(.PROPER(0), .SCAN_COUNT(CNT_KECCAK)) u_dut_keccak (
    .clk(clk), .rst(rst), .start(start0), .blobby(blob_w), .threshold(threshold),
    .ocapture(cap0), .ohash(hash0), .ononce(nonce0), .odispatching(disp0),
    .oawaiting(await0), .oevaluating(eval0), .scan_count(sc0)
  );

  assign m_cap   = sel0 ? cap0   : cap1;
  assign m_disp  = sel0 ? disp0  : disp1;
  assign m_await = sel0 ? await0 : await1;
  assign m_eval  = sel0 ? eval0  : eval1;
  assign m_hash  = sel0 ? hash0  : hash1;
  assign m_nonce = sel0 ? nonce0 : nonce1;

  // ---------------- reference model (FIPS 202 style) ----------------
  function automatic logic [63:0] rotl64(input logic [63:0] v, input int n);
    int m;
    m = n % 64;
    if (m == 0) return v;
    return (v << m) | (v >> (64 - m));
  endfunction

  function automatic logic [24:0][63:0] keccak_f(input logic [24:0][63:0] s);
    logic [63:0] a [5][5];
    logic [63:0] b [5][5];
    logic [63:0] c [5];
    int          r [5][5];
    int          x, y, nx;
    logic [7:0]  lfsr;
    logic [24:0][63:0] o;
    r[0][0] = 0;
    x = 1; y = 0;
    for (int t = 0; t < 24; t++) begin
      r[x][y] = ((t + 1) * (t + 2) / 2) % 64;
      nx = y; y = (2 * x + 3 * y) % 5; x = nx;
    end
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) a[i][j] = s[i + 5 * j];
    lfsr = 8'h01;
    for (int rnd = 0; rnd < 24; rnd++) begin
      for (int i = 0; i < 5; i++) c[i] = a[i][0] ^ a[i][1] ^ a[i][2] ^ a[i][3] ^ a[i][4];
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) a[i][j] = a[i][j] ^ c[(i + 4) % 5] ^ rotl64(c[(i + 1) % 5], 1);
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) b[j][(2 * i + 3 * j) % 5] = rotl64(a[i][j], r[i][j]);
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) a[i][j] = b[i][j] ^ (~b[(i + 1) % 5][j] & b[(i + 2) % 5][j]);
      for (int j = 0; j < 7; j++) begin
        if (lfsr[0]) a[0][0][(1 << j) - 1] = ~a[0][0][(1 << j) - 1];
        lfsr = lfsr[7] ? ((lfsr << 1) ^ 8'h71) : (lfsr << 1);
      end
    end
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) o[i + 5 * j] = a[i][j];
    return o;
  endfunction

  // Sponge view: message bytes little-endian, domain byte after the message,
  // 0x80 in the last byte of the 136-byte rate, then one permutation.
  function automatic logic [24:0][63:0] model_hash(input bit legacy, input logic [31:0] nonce);
    logic [7:0]        msg [200];
    logic [31:0]       w;
    logic [24:0][63:0] st;
    int                ie;
    ie = legacy ? 24 : 20;
    for (int i = 0; i < 200; i++) msg[i] = 8'h00;
    for (int i = 0; i < ie; i++) begin
      w = (i == ie - 1) ? nonce : blob_w[i];
      for (int k = 0; k < 4; k++) msg[4 * i + k] = w[8 * k +: 8];
    end
    msg[4 * ie] = msg[4 * ie] ^ (legacy ? 8'h01 : 8'h06);
    msg[135]    = msg[135] ^ 8'h80;
    for (int l = 0; l < 25; l++)
      for (int k = 0; k < 8; k++) st[l][8 * k +: 8] = msg[8 * l + k];
    return keccak_f(st);
  endfunction

  // Runs one scan on the selected core and checks every cycle until one cycle
  // past the final EVAL. poke adds a start pulse at cycle 5 that must be ignored.
  task automatic run_scan(input bit legacy, input logic [63:0] thr, input bit poke, input string name);
    logic [24:0][63:0] exp_hash [4];
    logic [31:0]       exp_nonce [4];
    logic [3:0]        exp_flags, got_flags;
    int                ie, cnt, n_eval, cap_idx, last_eval, k, bad_lane;
    bit                is_eval;
    ie = legacy ? 24 : 20;
    cnt = legacy ? CNT_KECCAK : CNT_SHA3;
    cap_idx = -1;
    n_eval = 0;
    for (int kk = 0; kk < cnt; kk++) begin
      exp_nonce[kk] = blob_w[ie - 1] + 32'(kk);
      exp_hash[kk]  = model_hash(legacy, exp_nonce[kk]);
      n_eval = kk + 1;
      if (exp_hash[kk][0] <= thr) begin
        cap_idx = kk;
        break;
      end
    end
    last_eval = n_eval * PERIOD;

    @(negedge clk);
    sel0 = legacy;
    threshold = thr;
    if (legacy) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    for (int cyc = 1; cyc <= last_eval + 1; cyc++) begin
      if (poke && cyc == 6) begin start0 = 1'b0; start1 = 1'b0; end
      is_eval = ((cyc % PERIOD) == 0) && (cyc <= last_eval);
      k = cyc / PERIOD - 1;
      exp_flags = {is_eval, is_eval && (k == cap_idx), cyc < last_eval, cyc <= last_eval};
      got_flags = {m_eval, m_cap, m_disp, m_await};
      n_compared++;
      if (got_flags !== exp_flags) begin
        n_mismatched++;
        $display("FAIL %s flags(eval,cap,disp,await) cyc %0d: got %b expected %b", name, cyc, got_flags, exp_flags);
      end
      if (is_eval) begin
        n_compared++;
        if (m_nonce !== exp_nonce[k]) begin
          n_mismatched++;
          $display("FAIL %s ononce eval %0d: got %h expected %h", name, k, m_nonce, exp_nonce[k]);
        end
        if (k == cap_idx) begin
          n_compared++;
          if (m_hash !== exp_hash[k]) begin
            n_mismatched++;
            bad_lane = 0;
            for (int l = 24; l >= 0; l--) if (m_hash[l] !== exp_hash[k][l]) bad_lane = l;
            $display("FAIL %s ohash lane %0d: got %h expected %h", name, bad_lane, m_hash[bad_lane], exp_hash[k][bad_lane]);
          end
        end
      end
      if (poke && cyc == 5) begin
        if (legacy) start0 = 1'b1; else start1 = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_compared++;
    if ({cap1, disp1, await1, eval1, cap0, disp0, await0, eval0} !== 8'h00 ||
        hash1 !== '0 || hash0 !== '0 || nonce1 !== '0 || nonce0 !== '0) begin
      n_mismatched++;
      $display("FAIL reset_outputs: got flags %b%b%b%b %b%b%b%b nonce %h %h, expected all zero",
               cap1, disp1, await1, eval1, cap0, disp0, await0, eval0, nonce1, nonce0);
    end
    n_compared++;
    if (sc1 !== 32'd4 || sc0 !== 32'd3) begin
      n_mismatched++;
      $display("FAIL reset_scan_count: got %0d/%0d expected 4/3", sc1, sc0);
    end
    // start together with rst: reset must win
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    rst = 1'b0;
    n_compared++;
    if (await1 !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_vs_start: oawaiting got %b expected 0", await1);
    end
    @(negedge clk);
    n_compared++;
    if (await1 !== 1'b0 || disp1 !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_vs_start_after: await/disp got %b%b expected 00", await1, disp1);
    end
  endtask

  task automatic test_sha3_zero();
    blob_w = '0;
    run_scan(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "sha3_zero");
  endtask

  task automatic test_nonce_wrap();
    blob_w = '0;
    blob_w[19] = 32'hFFFF_FFFE;
    run_scan(1'b0, 64'h0, 1'b0, "nonce_wrap");
  endtask

  task automatic test_busy_start();
    for (int i = 0; i < 24; i++) blob_w[i] = $urandom;
    run_scan(1'b0, 64'h0, 1'b1, "busy_start");
  endtask

  task automatic test_reset_mid_scan();
    int captures;
    for (int i = 0; i < 24; i++) blob_w[i] = $urandom;
    sel0 = 1'b0;
    threshold = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_compared++;
    if ({cap1, disp1, await1, eval1} !== 4'b0000 || hash1 !== '0 || nonce1 !== '0) begin
      n_mismatched++;
      $display("FAIL reset_mid_scan: flags %b%b%b%b nonce %h lane0 %h, expected all zero",
               cap1, disp1, await1, eval1, nonce1, hash1[0]);
    end
    captures = 0;
    for (int c = 0; c < 40; c++) begin
      if (cap1 === 1'b1 || await1 === 1'b1) captures++;
      @(negedge clk);
    end
    n_compared++;
    if (captures != 0) begin
      n_mismatched++;
      $display("FAIL reset_mid_scan_quiet: got %0d active cycles expected 0", captures);
    end
    run_scan(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "after_reset");
  endtask

  task automatic test_keccak_legacy();
    blob_w = '0;
    run_scan(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "keccak_zero");
  endtask

  task automatic test_random();
    logic [24:0][63:0] h;
    logic [63:0]       thr;
    bit                legacy;
    int                ie, cnt;
    for (int it = 0; it < 6; it++) begin
      legacy = 1'($urandom_range(0, 1));
      ie  = legacy ? 24 : 20;
      cnt = legacy ? CNT_KECCAK : CNT_SHA3;
      for (int i = 0; i < 24; i++) blob_w[i] = $urandom;
      if (it % 3 == 2) begin
        thr = {$urandom, $urandom};
      end else begin
        h = model_hash(legacy, blob_w[ie - 1] + 32'($urandom_range(0, cnt - 1)));
        thr = h[0];
      end
      run_scan(legacy, thr, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_sha3_zero();
    test_nonce_wrap();
    test_busy_start();
    test_reset_mid_scan();
    test_keccak_legacy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/sha3_nonce_scan_core.md
Name: sha3_nonce_scan_core

Overview:
- Iterative SHA3/Keccak nonce scanner.
- Latches an 80- or 96-byte work blob and walks a 32-bit nonce field through SCAN_COUNT consecutive values.
- For each nonce: one Keccak-f[1600] permutation at one round per clock, then a test of hash lane 0 against a 64-bit threshold.
- Sits behind the scanner instantiator, which buffers inputs/outputs and owns result validity; this core only pulses a capture strobe.

Parameters:
- PROPER, 1, 1 = SHA3-256 padding with 20 input words; 0 = legacy Keccak padding with 24 input words.
- SCAN_COUNT, 4096, number of nonces tested per start (1..2^32-1).
- INPUT_ELEMENTS, PROPER ? 20 : 24, localparam; count of 32-bit blob words.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle strobe; honoured only when dispatching=0 and awaiting=0.
- blobby  in  32 x INPUT_ELEMENTS  work blob, sampled on an honoured start.
- threshold  in  64  unsigned difficulty limit, sampled every cycle.
- ocapture  out  1  one-cycle pulse: ohash/ononce hold a passing result this cycle.
- ohash  out  64 x 25  permuted state lanes, lane index = x+5y.
- ononce  out  32  nonce that produced ohash.
- odispatching  out  1  more nonces remain to be tested.
- oawaiting  out  1  a hash is in flight.
- oevaluating  out  1  threshold comparison happening this cycle.
- scan_count  out  32  constant SCAN_COUNT.

Behaviour:
- Reset: state IDLE; all outputs 0 except scan_count; state array and counters cleared. Reset mid-scan aborts with no capture.
- Lane packing: lane i = {blobby[2i+1], blobby[2i]}.
- Nonce field is blobby[INPUT_ELEMENTS-1]. First nonce = latched value of that word; nonces increment by 1, wrapping mod 2^32.
- PROPER=1 load: lanes 0..9 from blob; lane10=0x06; lane16=0x8000_0000_0000_0000; all others 0.
- PROPER=0 load: lanes 0..11 from blob; lane12=0x01; lane16=0x8000_0000_0000_0000; all others 0.
- FSM: IDLE -> LOAD -> ROUND -> EVAL.
  - IDLE -> LOAD on an honoured start.
  - LOAD: builds the state with the current nonce; 1 clock.
  - ROUND: 24 clocks, round index 0..23; each is theta, rho, pi, chi, iota with the standard RC[i].
  - EVAL: 1 clock; oevaluating=1. Pass if lane0 <= threshold (unsigned); on pass, ocapture=1 with ohash = final state and ononce = tested nonce.
  - From EVAL: if pass, or tested count == SCAN_COUNT, go to IDLE; otherwise go to LOAD with nonce+1.
- Period: 26 clocks per nonce. Start sampled at edge N gives the first EVAL at cycle N+26.
- odispatching: 1 from LOAD until the EVAL that passes or the EVAL of the final nonce; it falls in that EVAL cycle.
- oawaiting: 1 in LOAD, ROUND and EVAL; 0 in IDLE.
- ohash/ononce: hold their last values outside EVAL. The consumer must use only the ocapture cycle.
- Start while busy is ignored. Start in the same cycle as rst: rst wins.
- threshold may change mid-scan; the value present in the EVAL cycle is used.

Optional Feature:
- Macro SHA3_SCAN_DOUBLE_ROUND_EN.
- Defined: two rounds per clock; ROUND lasts 12 clocks; period 14 clocks; first EVAL at N+14. Results are bit-identical to the single-round build.
- Undefined: one round per clock as above.

Decomposition:
- Package sha3_scan_pkg:
  - lane_t (64-bit) and state_t (lane_t[25]) typedefs.
  - RC[24] round constants.
  - ROT[25] rho offsets.
  - Pad constants (0x06, 0x01, 0x8000_0000_0000_0000).
  - FSM state enum.
- Sub-module sha3_round: purely combinational single Keccak round taking state_t and round index. Instantiated once, or twice chained under the macro.

Test Plan:
- PROPER=1, blobby all 0, threshold=64'hFFFF_FFFF_FFFF_FFFF, start at cycle N -> ocapture at N+26; ononce=0; ohash lanes 0..3 equal the software SHA3-256 digest of 80 zero bytes; odispatching and oawaiting return to 0 the next cycle.
- threshold=0, SCAN_COUNT=4, blobby[19]=32'hFFFF_FFFE -> 4 EVAL pulses at 26-clock spacing, no ocapture; nonces wrap FFFF_FFFE, FFFF_FFFF, 0, 1; oawaiting falls after the 4th EVAL.
- Mid-scan start pulse (cycle N+5) -> ignored; ononce/timing identical to an unperturbed run.
- rst asserted at N+10 during ROUND -> all outputs 0 the next cycle; no ocapture; a new start then runs a full 26-cycle nonce.
- PROPER=0, blobby all 0, threshold all-ones -> ohash equals a golden-model Keccak-f of the state with lane12=0x01 and lane16 MSB set; ononce=0.
- SHA3_SCAN_DOUBLE_ROUND_EN defined, repeat the first scenario -> same ohash; ocapture at N+14.
